// File: rtl/hazard_requester_if.sv
// Shared types and the request/response interface between the pipeline-side
// requester and the hazard unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } memaccess_t;

  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JAL    = 2'd2,
    NPC_JALR   = 2'd3
  } nextpc_mode_t;

  // Hazard-relevant slice of one pipeline stage
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       regwrite;
    memaccess_t memaccess;
  } stage_t;

  typedef struct packed {
    logic load_use;
    logic branch_mispredict;
  } hazard_cause_t;

  typedef struct packed {
    logic [4:0]   rs1_d;
    logic [4:0]   rs2_d;
    logic [4:0]   rd_d;
    nextpc_mode_t nextpc_mode;
    logic         pcsrc;
    logic         flushflag;
    logic [4:0]   rs1_e;
    logic [4:0]   rs2_e;
    logic [4:0]   rd_e;
    logic         regwrite_e;
    memaccess_t   memaccess_e;
    logic [4:0]   rs2_m;
    logic [4:0]   rd_m;
    logic         regwrite_m;
    memaccess_t   memaccess_m;
    logic [4:0]   rd_w;
    logic         regwrite_w;
  } hazard_req_t;

  typedef struct packed {
    logic          stall_f;
    logic          stall_d;
    logic          flush_d;
    logic          flush_e;
    logic          flush_m;
    hazard_cause_t hazard_cause;
  } hazard_res_t;

endpackage

interface hazard_interface;
  import hazard_pkg::*;

  hazard_req_t req;
  hazard_res_t res;

  modport requester (output req, input res);
  modport unit      (input req, output res);
endinterface

// File: rtl/hazard_requester.sv
// Owns the E/M/W hazard control records and builds the hazard request bundle.
// Performance counters exist only when HAZARD_PERF_EN is defined.
module hazard_requester
  import hazard_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  hazard_interface.requester    hazard_bus,
  input  logic [4:0]            rs1_d,
  input  logic [4:0]            rs2_d,
  input  logic [4:0]            rd_d,
  input  logic                  regwrite_d,
  input  memaccess_t            memaccess_d,
  input  nextpc_mode_t          nextpc_mode,
  input  logic                  pcsrc,
  input  logic                  trap_req,
  input  logic                  perf_clr,
  output logic [PERF_W-1:0]     perf_stall,
  output logic [PERF_W-1:0]     perf_load_use,
  output logic [PERF_W-1:0]     perf_mispredict,
  output logic [PERF_W-1:0]     perf_flush
);

  localparam stage_t BUBBLE = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
                                regwrite: 1'b0, memaccess: MEM_NONE};

  stage_t decRec;
  stage_t eStage_q, eStage_d;
  stage_t mStage_q, mStage_d;
  stage_t wStage_q, wStage_d;
  logic   flushFlag;

  assign decRec = '{rs1: rs1_d, rs2: rs2_d, rd: rd_d,
                    regwrite: regwrite_d, memaccess: memaccess_d};

  assign flushFlag = start && trap_req;

  // Stall on decode never holds E; the hazard unit pairs it with flush_e.
  always_comb begin
    eStage_d = decRec;
    mStage_d = eStage_q;
    wStage_d = mStage_q;
    if (!start || hazard_bus.res.flush_e) eStage_d = BUBBLE;
    if (!start || hazard_bus.res.flush_m) mStage_d = BUBBLE;
    if (!start)                           wStage_d = BUBBLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eStage_q <= BUBBLE;
      mStage_q <= BUBBLE;
      wStage_q <= BUBBLE;
    end else begin
      eStage_q <= eStage_d;
      mStage_q <= mStage_d;
      wStage_q <= wStage_d;
    end
  end

  // Request is built only from inputs and stage registers, never from res.
  always_comb begin
    hazard_bus.req             = '0;
    hazard_bus.req.rs1_d       = rs1_d;
    hazard_bus.req.rs2_d       = rs2_d;
    hazard_bus.req.rd_d        = rd_d;
    hazard_bus.req.nextpc_mode = nextpc_mode;
    hazard_bus.req.pcsrc       = pcsrc;
    hazard_bus.req.flushflag   = flushFlag;
    hazard_bus.req.rs1_e       = eStage_q.rs1;
    hazard_bus.req.rs2_e       = eStage_q.rs2;
    hazard_bus.req.rd_e        = eStage_q.rd;
    hazard_bus.req.regwrite_e  = eStage_q.regwrite;
    hazard_bus.req.memaccess_e = eStage_q.memaccess;
    hazard_bus.req.rs2_m       = mStage_q.rs2;
    hazard_bus.req.rd_m        = mStage_q.rd;
    hazard_bus.req.regwrite_m  = mStage_q.regwrite;
    hazard_bus.req.memaccess_m = mStage_q.memaccess;
    hazard_bus.req.rd_w        = wStage_q.rd;
    hazard_bus.req.regwrite_w  = wStage_q.regwrite;
  end

`ifdef HAZARD_PERF_EN

  logic [PERF_W-1:0] stallCnt_q, stallCnt_d;
  logic [PERF_W-1:0] loadUseCnt_q, loadUseCnt_d;
  logic [PERF_W-1:0] mispredCnt_q, mispredCnt_d;
  logic [PERF_W-1:0] flushCnt_q, flushCnt_d;

  function automatic logic [PERF_W-1:0] satInc(input logic [PERF_W-1:0] cnt,
                                                input logic ev);
    if (ev && (cnt != {PERF_W{1'b1}})) return cnt + PERF_W'(1);
    return cnt;
  endfunction

  // Clear wins over any same-cycle event; nothing counts while stopped.
  always_comb begin
    stallCnt_d   = stallCnt_q;
    loadUseCnt_d = loadUseCnt_q;
    mispredCnt_d = mispredCnt_q;
    flushCnt_d   = flushCnt_q;
    if (perf_clr) begin
      stallCnt_d   = '0;
      loadUseCnt_d = '0;
      mispredCnt_d = '0;
      flushCnt_d   = '0;
    end else if (start) begin
      stallCnt_d   = satInc(stallCnt_q,   hazard_bus.res.stall_d);
      loadUseCnt_d = satInc(loadUseCnt_q, hazard_bus.res.hazard_cause.load_use);
      mispredCnt_d = satInc(mispredCnt_q, hazard_bus.res.hazard_cause.branch_mispredict);
      flushCnt_d   = satInc(flushCnt_q,   flushFlag);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCnt_q   <= '0;
      loadUseCnt_q <= '0;
      mispredCnt_q <= '0;
      flushCnt_q   <= '0;
    end else begin
      stallCnt_q   <= stallCnt_d;
      loadUseCnt_q <= loadUseCnt_d;
      mispredCnt_q <= mispredCnt_d;
      flushCnt_q   <= flushCnt_d;
    end
  end

  assign perf_stall      = stallCnt_q;
  assign perf_load_use   = loadUseCnt_q;
  assign perf_mispredict = mispredCnt_q;
  assign perf_flush      = flushCnt_q;

  logic unusedBits;
  assign unusedBits = ^{hazard_bus.res.stall_f, hazard_bus.res.flush_d,
                        mStage_q.rs1, wStage_q.rs1, wStage_q.rs2, wStage_q.memaccess};

`else

  assign perf_stall      = '0;
  assign perf_load_use   = '0;
  assign perf_mispredict = '0;
  assign perf_flush      = '0;

  logic unusedBits;
  assign unusedBits = ^{hazard_bus.res, perf_clr,
                        mStage_q.rs1, wStage_q.rs1, wStage_q.rs2, wStage_q.memaccess};

`endif

endmodule

// File: tb/tb_hazard_requester.sv
// Directed self-checking bench for hazard_requester; the bench plays the
// hazard unit by driving the response bundle by hand.
module tb_hazard_requester;
  import hazard_pkg::*;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [4:0]    rs1_d, rs2_d, rd_d;
  logic          regwrite_d;
  memaccess_t    memaccess_d;
  nextpc_mode_t  nextpc_mode;
  logic          pcsrc;
  logic          trap_req;
  logic          perf_clr;
  logic [PW-1:0] perf_stall, perf_load_use, perf_mispredict, perf_flush;

  int nAssert = 0;
  int nFail   = 0;

  hazard_interface hbus ();

  hazard_requester #(.PERF_W(PW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .hazard_bus      (hbus.requester),
    .rs1_d           (rs1_d),
    .rs2_d           (rs2_d),
    .rd_d            (rd_d),
    .regwrite_d      (regwrite_d),
    .memaccess_d     (memaccess_d),
    .nextpc_mode     (nextpc_mode),
    .pcsrc           (pcsrc),
    .trap_req        (trap_req),
    .perf_clr        (perf_clr),
    .perf_stall      (perf_stall),
    .perf_load_use   (perf_load_use),
    .perf_mispredict (perf_mispredict),
    .perf_flush      (perf_flush)
  );

  always #5 clk = ~clk;

  function automatic int perfExp(input int n);
    return PERF ? n : 0;
  endfunction

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic rw,
                               input memaccess_t mem);
    rs1_d       = rs1;
    rs2_d       = rs2;
    rd_d        = rd;
    regwrite_d  = rw;
    memaccess_d = mem;
    #1;
  endtask

  task automatic setRes(input logic stallD, input logic flushD, input logic flushE,
                        input logic flushM, input logic lu, input logic bm);
    hbus.res.stall_f                        = stallD;
    hbus.res.stall_d                        = stallD;
    hbus.res.flush_d                        = flushD;
    hbus.res.flush_e                        = flushE;
    hbus.res.flush_m                        = flushM;
    hbus.res.hazard_cause.load_use          = lu;
    hbus.res.hazard_cause.branch_mispredict = bm;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nAssert++;
    assert (observed === expected)
      else begin
        nFail++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  task automatic checkStages(input string tag, input int rdE, input int rdM, input int rdW);
    checkOutput({tag, " rd_e"}, int'(hbus.req.rd_e), rdE);
    checkOutput({tag, " rd_m"}, int'(hbus.req.rd_m), rdM);
    checkOutput({tag, " rd_w"}, int'(hbus.req.rd_w), rdW);
  endtask

  task automatic checkPerf(input string tag, input int st, input int lu,
                           input int mp, input int fl);
    checkOutput({tag, " perf_stall"},      int'(perf_stall),      perfExp(st));
    checkOutput({tag, " perf_load_use"},   int'(perf_load_use),   perfExp(lu));
    checkOutput({tag, " perf_mispredict"}, int'(perf_mispredict), perfExp(mp));
    checkOutput({tag, " perf_flush"},      int'(perf_flush),      perfExp(fl));
  endtask

  initial begin
    // Reset has priority even with start high and a live decode record
    rst_n       = 1'b0;
    start       = 1'b1;
    nextpc_mode = NPC_PLUS4;
    pcsrc       = 1'b0;
    trap_req    = 1'b0;
    perf_clr    = 1'b0;
    setRes(0, 0, 0, 0, 0, 0);
    applyStimulus(5'd1, 5'd2, 5'd9, 1'b1, MEM_LOAD);
    step();
    step();
    checkStages("reset", 0, 0, 0);
    checkOutput("reset regwrite_e", int'(hbus.req.regwrite_e), 0);
    checkOutput("reset memaccess_e", int'(hbus.req.memaccess_e), int'(MEM_NONE));
    checkOutput("reset rs1_e", int'(hbus.req.rs1_e), 0);
    checkPerf("reset", 0, 0, 0, 0);

    // Single instruction walks D->E->M->W
    rst_n = 1'b1;
    nextpc_mode = NPC_JALR;
    applyStimulus(5'd1, 5'd2, 5'd5, 1'b1, MEM_NONE);
    checkOutput("pass rd_d", int'(hbus.req.rd_d), 5);
    checkOutput("pass rs2_d", int'(hbus.req.rs2_d), 2);
    checkOutput("pass nextpc_mode", int'(hbus.req.nextpc_mode), int'(NPC_JALR));
    step();
    checkStages("walk1", 5, 0, 0);
    checkOutput("walk1 regwrite_e", int'(hbus.req.regwrite_e), 1);
    nextpc_mode = NPC_PLUS4;
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, MEM_NONE);
    step();
    checkStages("walk2", 0, 5, 0);
    checkOutput("walk2 regwrite_m", int'(hbus.req.regwrite_m), 1);
    checkOutput("walk2 rs2_m", int'(hbus.req.rs2_m), 2);
    step();
    checkStages("walk3", 0, 0, 5);
    checkOutput("walk3 regwrite_w", int'(hbus.req.regwrite_w), 1);

    // Load-use: lw x3, then add x6,x3,x4 stalls one cycle
    applyStimulus(5'd1, 5'd0, 5'd3, 1'b1, MEM_LOAD);
    step();
    checkOutput("lw memaccess_e", int'(hbus.req.memaccess_e), int'(MEM_LOAD));
    applyStimulus(5'd3, 5'd4, 5'd6, 1'b1, MEM_NONE);
    setRes(1, 0, 1, 0, 1, 0);
    step();
    checkStages("loaduse", 0, 3, 0);
    checkOutput("loaduse memaccess_e", int'(hbus.req.memaccess_e), int'(MEM_NONE));
    checkOutput("loaduse memaccess_m", int'(hbus.req.memaccess_m), int'(MEM_LOAD));
    checkPerf("loaduse", 1, 1, 0, 0);
    setRes(0, 0, 0, 0, 0, 0);
    step();
    checkStages("afterlu", 6, 0, 3);
    checkOutput("afterlu rs1_e", int'(hbus.req.rs1_e), 3);

    // Taken branch flushes the wrong-path decode record out of E
    applyStimulus(5'd0, 5'd0, 5'd7, 1'b1, MEM_NONE);
    pcsrc = 1'b1;
    setRes(0, 1, 1, 0, 0, 1);
    checkOutput("branch pcsrc", int'(hbus.req.pcsrc), 1);
    step();
    checkStages("branch", 0, 6, 0);
    checkPerf("branch", 1, 1, 1, 0);
    pcsrc = 1'b0;
    setRes(0, 0, 0, 0, 0, 0);

    // Trap with valid E and M records
    applyStimulus(5'd0, 5'd0, 5'd8, 1'b1, MEM_STORE);
    step();
    applyStimulus(5'd0, 5'd0, 5'd9, 1'b1, MEM_NONE);
    step();
    checkStages("pretrap", 9, 8, 0);
    trap_req = 1'b1;
    setRes(0, 1, 1, 1, 0, 0);
    checkOutput("trap flushflag", int'(hbus.req.flushflag), 1);
    step();
    checkStages("trap", 0, 0, 8);
    checkOutput("trap regwrite_w", int'(hbus.req.regwrite_w), 1);
    checkPerf("trap", 1, 1, 1, 1);
    trap_req = 1'b0;
    setRes(0, 0, 0, 0, 0, 0);
    checkOutput("trap flushflag off", int'(hbus.req.flushflag), 0);

    // Stop mid-stream: bubbles, frozen counters, no replay on restart
    applyStimulus(5'd0, 5'd0, 5'd10, 1'b1, MEM_NONE);
    step();
    applyStimulus(5'd0, 5'd0, 5'd11, 1'b1, MEM_NONE);
    step();
    checkStages("prestop", 11, 10, 0);
    start    = 1'b0;
    trap_req = 1'b1;
    setRes(1, 0, 0, 0, 1, 1);
    checkOutput("stop flushflag", int'(hbus.req.flushflag), 0);
    step();
    checkStages("stop1", 0, 0, 0);
    step();
    checkStages("stop2", 0, 0, 0);
    checkOutput("stop2 regwrite_e", int'(hbus.req.regwrite_e), 0);
    checkPerf("stop2", 1, 1, 1, 1);
    start    = 1'b1;
    trap_req = 1'b0;
    setRes(0, 0, 0, 0, 0, 0);
    applyStimulus(5'd0, 5'd0, 5'd12, 1'b1, MEM_NONE);
    step();
    checkStages("restart", 12, 0, 0);

    // Flush counter saturation, then clear beating a same-cycle event
    trap_req = 1'b1;
    setRes(0, 1, 1, 1, 0, 0);
    for (int i = 0; i < (1 << PW) + 3; i++) step();
    checkPerf("saturate", 1, 1, 1, 15);
    perf_clr = 1'b1;
    step();
    checkPerf("clear", 0, 0, 0, 0);
    perf_clr = 1'b0;
    step();
    checkPerf("postclear", 0, 0, 0, 1);
    trap_req = 1'b0;
    setRes(0, 0, 0, 0, 0, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/hazard_requester.md
# hazard_requester

Requester-side companion to the hazard unit. Owns the hazard-relevant control fields of the E, M and W pipeline stages and builds the `hazard_bus.req` bundle each cycle. Applies the returned stall/flush responses to its own stage registers so the bundle stays consistent with the datapath. Optionally keeps hazard performance counters. Sits in the core top level between decode/execute control and the hazard interface.

## Interface
Parameters:
- `PERF_W`, 32: width of each performance counter.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  core run enable; low forces all stage registers to bubble.
- `hazard_bus`  modport `hazard_interface.requester`  drives `req`, samples `res`.
- `rs1_d`, `rs2_d`, `rd_d`  in  5 each  decode-stage register indices.
- `regwrite_d`  in  1  decode instruction writes rd.
- `memaccess_d`  in  `memaccess_t`  MEM_NONE / MEM_LOAD / MEM_STORE.
- `nextpc_mode`  in  `nextpc_mode_t`  decode next-PC mode, passed through to `req`.
- `pcsrc`  in  1  execute-stage redirect (taken branch/jump).
- `trap_req`  in  1  trap/exception redirect request.
- `perf_clr`  in  1  synchronous clear of all counters.
- `perf_stall`, `perf_load_use`, `perf_mispredict`, `perf_flush`  out  `PERF_W` each  counters.

## Operation
- Stage record is {rs1, rs2, rd, regwrite, memaccess}. Bubble: all fields zero, memaccess = MEM_NONE.
- `req` fields: `rs*_d`/`rd`-related D fields, `nextpc_mode` and `pcsrc` are taken combinationally from inputs. E/M/W fields come from the registers. `rs2_m` is the M-record rs2.
- `req.flushflag = start && trap_req`. Combinational; no latching.
- E register: `!start || res.flush_e` → bubble; otherwise load the D record. `res.stall_d` does not hold E. A load-use stall is always paired with `flush_e`.
- M register: `!start || res.flush_m` → bubble; otherwise load E.
- W register: `!start` → bubble; otherwise load M. There is no W flush.
- Flush takes priority over load at every stage. Reset takes priority over everything.
- rd = 0 with `regwrite` = 1 is stored as-is. Filtering of x0 is the hazard unit's job.
- Counters, each incremented at most once per cycle:
  - `perf_stall` increments when `res.stall_d` is set.
  - `perf_load_use` increments when `res.hazard_cause.load_use` is set.
  - `perf_mispredict` increments when `res.hazard_cause.branch_mispredict` is set.
  - `perf_flush` increments when `req.flushflag` is set.
- Counters saturate at all-ones. `perf_clr` beats increment in the same cycle.
- Counters count only while `start` = 1.

## Timing
- Reset (`rst_n` = 0 at a `clk` edge): E/M/W records are bubbles and all counters are 0. Hence all registered `req` fields are 0.
- D→E, E→M and M→W are each 1 cycle. An instruction's rd appears as `rd_e`, `rd_m` and `rd_w` in 3 consecutive cycles unless flushed.
- `res` is sampled in the same cycle it is produced (combinational loop through the hazard unit). The block adds no combinational path from `res` to `req`.
- Simultaneous `flushflag` and load-use: `flush_e` wins, so E becomes a bubble; M also becomes a bubble.
- Deasserting `start` mid-operation: bubbles are inserted from the next edge. Reasserting resumes from bubbles with no replay.

## Configuration
- `HAZARD_PERF_EN` defined: counters are implemented as above.
- `HAZARD_PERF_EN` undefined: no counter flops; all `perf_*` outputs are tied to 0; `perf_clr` is ignored. Stage and `req` behaviour is identical in both builds.

## Test plan
- Reset, then `start` = 1 with D record {rd = 5, regwrite = 1, MEM_NONE}:
  - `rd_e` = 5 after 1 edge, `rd_m` = 5 after 2, `rd_w` = 5 after 3.
  - `regwrite_e/m/w` follow the same sequence.
- Load-use: D = lw x3, then D = add with rs1 = 3:
  - The hazard unit asserts `stall_d` and `flush_e` for 1 cycle.
  - E holds a bubble (`rd_e` = 0, MEM_NONE) for that cycle.
  - `perf_stall` = 1 and `perf_load_use` = 1.
- Taken branch: `pcsrc` = 1 with `flush_d` and `flush_e` asserted → next-cycle E is a bubble and `perf_mispredict` increments by 1.
- Trap: `trap_req` = 1 for 1 cycle with E/M holding valid records:
  - `flushflag` = 1 in that same cycle.
  - E and M become bubbles on the next edge.
  - W receives the old M record.
  - `perf_flush` = 1.
- Hold `trap_req` = 1 for 2^`PERF_W`+3 cycles with a reduced `PERF_W` = 4 build → `perf_flush` sticks at 15. Assert `perf_clr` together with an event → counter reads 0 on the next cycle.
- Drop `start` for 2 cycles mid-stream → all registered `req` fields read 0 and counters do not change. Build without `HAZARD_PERF_EN` → all `perf_*` outputs read 0 throughout.
